// File: rtl/pkmc_sdram_cmdgen.sv
// pkmc_sdram_cmdgen -- SDRAM command/address sequencer for the PKMC controller.
//
// Turns a single-word request (byte address + read/write) into a timed
// PRECHARGE / ACTIVE / READ / WRITE sequence. It keeps an open-row table per
// bank and services refresh and load-mode-register requests. Command, address
// and bank lines are registered. Downstream data/CAS capture keys off ack_o.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, we_i, addr_i     access request (held until ack_o)
//   ref_req_i               refresh request (held until ref_ack_o)
//   lmr_req_i               load-mode request (held until lmr_ack_o)
//   cmd_o                   {ras_n, cas_n, we_n}
//   addr_o, bank_o          SDRAM A and BA buses
//   ack_o, ref_ack_o,
//   lmr_ack_o               one-cycle pulses alongside RD/WR, REF, LMR
//   busy_o                  high while the sequencer is not idle
//
// Build option: define PKMC_AUTO_PRECHARGE_EN for a close-page policy
// (RD/WR with auto-precharge, A10 = 1). Undefined gives open-page.
module pkmc_sdram_cmdgen #(
  parameter int ADDR_W       = 32,
  parameter int SDRAM_ADDR_W = 13,
  parameter int BANK_W       = 2,
  parameter int ROW_W        = 13,
  parameter int COL_W        = 9,
  parameter int COL_LSB      = 2,
  parameter int ROW_LSB      = 11,
  parameter int BANK_LSB     = 24,
  parameter int T_RP         = 2,
  parameter int T_RCD        = 2,
  parameter int T_RFC        = 7,
  parameter logic [SDRAM_ADDR_W-1:0] MODE_WORD = 13'h022
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic                    ref_req_i,
  input  logic                    lmr_req_i,
  output logic [2:0]              cmd_o,
  output logic [SDRAM_ADDR_W-1:0] addr_o,
  output logic [BANK_W-1:0]       bank_o,
  output logic                    ack_o,
  output logic                    ref_ack_o,
  output logic                    lmr_ack_o,
  output logic                    busy_o
);

  localparam int NB     = 1 << BANK_W;
  localparam int T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int T_MAX  = (T_MAX0 > T_RFC) ? T_MAX0 : T_RFC;
  localparam int CNT_W  = $clog2(T_MAX + 1);

  // Counter load values: a wait of T cycles is the command cycle plus T-1.
  localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RCD_LD  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RFC_LD  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW, S_REF, S_REF_WAIT, S_LMR
  } state_t;

  typedef enum logic [1:0] { OP_ACC, OP_REF, OP_LMR } op_t;

  state_t state_q, state_n;
  op_t    op_q, op_n;
  logic [CNT_W-1:0]           cnt_q;
  logic [NB-1:0]              valid_q;
  logic [NB-1:0][ROW_W-1:0]   row_q;

  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              bank_open, row_hit, any_open, ap_block;

  logic [2:0]              cmd_n;
  logic [SDRAM_ADDR_W-1:0] addr_n;
  logic [BANK_W-1:0]       bank_n;

  assign bank      = addr_i[BANK_LSB +: BANK_W];
  assign row       = addr_i[ROW_LSB +: ROW_W];
  assign col       = addr_i[COL_LSB +: COL_W];
  assign bank_open = valid_q[bank];
  assign row_hit   = bank_open && (row_q[bank] == row);
  assign any_open  = |valid_q;

  logic unused_addr;
  assign unused_addr = ^addr_i;

`ifdef PKMC_AUTO_PRECHARGE_EN
  localparam logic AP_BIT = 1'b1;
  logic [CNT_W-1:0]  ap_cnt_q;
  logic [BANK_W-1:0] ap_bank_q;

  // After an auto-precharged RD/WR the bank needs T_RP before the next ACT;
  // the request waits in IDLE while the hold is still running.
  assign ap_block = (ap_cnt_q != '0) && (ap_bank_q == bank);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ap_cnt_q  <= '0;
      ap_bank_q <= '0;
    end else if (state_n == S_RW) begin
      ap_cnt_q  <= RP_LD;
      ap_bank_q <= bank;
    end else if (ap_cnt_q != '0) begin
      ap_cnt_q  <= ap_cnt_q - CNT_ONE;
    end
  end
`else
  localparam logic AP_BIT = 1'b0;
  assign ap_block = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_ACC;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
    end
  end

  // Command states are only ever entered, never held, so a command state in
  // state_n means that command issues on the next edge.
  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (lmr_req_i) begin
          op_n    = OP_LMR;
          state_n = any_open ? S_PRE : S_LMR;
        end else if (ref_req_i) begin
          op_n    = OP_REF;
          state_n = any_open ? S_PRE : S_REF;
        end else if (req_i && !ap_block) begin
          op_n = OP_ACC;
          if (!bank_open)   state_n = S_ACT;
          else if (row_hit) state_n = S_RW;
          else              state_n = S_PRE;
        end
      end
      S_PRE, S_PRE_WAIT: begin
        if (cnt_q != '0)          state_n = S_PRE_WAIT;
        else if (op_q == OP_ACC)  state_n = S_ACT;
        else if (op_q == OP_REF)  state_n = S_REF;
        else                      state_n = S_LMR;
      end
      S_ACT, S_ACT_WAIT: state_n = (cnt_q != '0) ? S_ACT_WAIT : S_RW;
      S_REF, S_REF_WAIT: state_n = (cnt_q != '0) ? S_REF_WAIT : S_IDLE;
      S_RW, S_LMR:       state_n = S_IDLE;
      default:           state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_n  = CMD_NOP;
    addr_n = '0;
    bank_n = '0;
    case (state_n)
      S_PRE: begin
        cmd_n = CMD_PRE;
        if (op_n == OP_ACC) bank_n = bank;   // single bank, A10 = 0
        else                addr_n[10] = 1'b1; // all banks
      end
      S_ACT: begin
        cmd_n              = CMD_ACT;
        addr_n[ROW_W-1:0]  = row;
        bank_n             = bank;
      end
      S_RW: begin
        cmd_n              = we_i ? CMD_WR : CMD_RD;
        addr_n[COL_W-1:0]  = col;
        addr_n[10]         = AP_BIT;
        bank_n             = bank;
      end
      S_REF: cmd_n = CMD_REF;
      S_LMR: begin
        cmd_n  = CMD_LMR;
        addr_n = MODE_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      valid_q   <= '0;
      row_q     <= '0;
      cmd_o     <= CMD_NOP;
      addr_o    <= '0;
      bank_o    <= '0;
      ack_o     <= 1'b0;
      ref_ack_o <= 1'b0;
      lmr_ack_o <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      if      (state_n == S_PRE) cnt_q <= RP_LD;
      else if (state_n == S_ACT) cnt_q <= RCD_LD;
      else if (state_n == S_REF) cnt_q <= RFC_LD;
      else if (cnt_q != '0)      cnt_q <= cnt_q - CNT_ONE;

      if (state_n == S_ACT) begin
        valid_q[bank] <= 1'b1;
        row_q[bank]   <= row;
      end
      if (state_n == S_PRE) begin
        if (op_n == OP_ACC) valid_q[bank] <= 1'b0;
        else                valid_q       <= '0;
      end
`ifdef PKMC_AUTO_PRECHARGE_EN
      if (state_n == S_RW) valid_q[bank] <= 1'b0;
`endif

      cmd_o     <= cmd_n;
      addr_o    <= addr_n;
      bank_o    <= bank_n;
      ack_o     <= (state_n == S_RW);
      ref_ack_o <= (state_n == S_REF);
      lmr_ack_o <= (state_n == S_LMR);
      busy_o    <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_pkmc_sdram_cmdgen.sv
// Bench for pkmc_sdram_cmdgen: a vector table of requests with their expected
// path, expected commands queued at drive time and checked as the DUT issues
// them, plus hand sequences for held requests, refresh/access collision and
// reset in the middle of a sequence.
module tb_pkmc_sdram_cmdgen;
  localparam int T_RP = 2, T_RCD = 2, T_RFC = 7;
`ifdef PKMC_AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100,
                         PRE = 3'b010, REF = 3'b001, LMR = 3'b000;
  localparam int P_HIT = 0, P_MISS = 1, P_CLOSED = 2, P_OPEN = 3;
  localparam int K_ACC = 0, K_REF = 1, K_LMR = 2;

  logic clk = 1'b0, rst, req, we, ref_req, lmr_req;
  logic [31:0] addr;
  logic [2:0]  cmd_o;
  logic [12:0] addr_o;
  logic [1:0]  bank_o;
  logic ack_o, ref_ack_o, lmr_ack_o, busy_o;

  pkmc_sdram_cmdgen dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .ref_req_i(ref_req), .lmr_req_i(lmr_req), .cmd_o(cmd_o), .addr_o(addr_o),
    .bank_o(bank_o), .ack_o(ack_o), .ref_ack_o(ref_ack_o),
    .lmr_ack_o(lmr_ack_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] cmd;
    logic [12:0] a;
    logic [1:0] ba;
    logic       ack, rack, lack;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every non-NOP command or ack must match the queue head.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (cmd_o !== NOP || ack_o === 1'b1 || ref_ack_o === 1'b1 || lmr_ack_o === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cmd: got cmd=%b addr=%h bank=%0d at cycle %0d, expected none",
                 cmd_o, addr_o, bank_o, cyc);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.cmd !== cmd_o || e.a !== addr_o || e.ba !== bank_o ||
            e.ack !== ack_o || e.rack !== ref_ack_o || e.lack !== lmr_ack_o) begin
          errors++;
          $display("FAIL cmd_seq: got cyc=%0d cmd=%b a=%h ba=%0d acks=%b%b%b, expected cyc=%0d cmd=%b a=%h ba=%0d acks=%b%b%b",
                   cyc, cmd_o, addr_o, bank_o, ack_o, ref_ack_o, lmr_ack_o,
                   e.c, e.cmd, e.a, e.ba, e.ack, e.rack, e.lack);
        end
      end
    end
  end

  function automatic void push(input int c, input logic [2:0] cmd, input logic [12:0] a,
                               input logic [1:0] ba, input logic ack, input logic rack,
                               input logic lack);
    exp_t e;
    e.c = c; e.cmd = cmd; e.a = a; e.ba = ba; e.ack = ack; e.rack = rack; e.lack = lack;
    q.push_back(e);
  endfunction

  // Queue the command train for an access sampled in IDLE at cycle n;
  // returns the RD/WR (ack) cycle.
  function automatic int push_acc(input int n, input int path, input logic w,
                                  input logic [31:0] ad);
    logic [1:0]  ba;
    logic [12:0] rw, cl;
    int c;
    int p;
    p  = AP ? P_CLOSED : path;
    ba = ad[25:24];
    rw = ad[23:11];
    cl = {4'b0, ad[10:2]};
    if (AP) cl[10] = 1'b1;
    c = n + 1;
    if (p == P_MISS) begin
      push(c, PRE, 13'h000, ba, 1'b0, 1'b0, 1'b0);
      c += T_RP;
    end
    if (p != P_HIT) begin
      push(c, ACT, rw, ba, 1'b0, 1'b0, 1'b0);
      c += T_RCD;
    end
    push(c, w ? WR : RD, cl, ba, 1'b1, 1'b0, 1'b0);
    return c;
  endfunction

  // Refresh or LMR sampled at n; returns the REF/LMR cycle.
  function automatic int push_ref(input int n, input int path, input bit is_lmr);
    int c;
    c = n + 1;
    if (!AP && path == P_OPEN) begin
      push(c, PRE, 13'h400, 2'd0, 1'b0, 1'b0, 1'b0);
      c += T_RP;
    end
    if (is_lmr) push(c, LMR, 13'h022, 2'd0, 1'b0, 1'b0, 1'b1);
    else        push(c, REF, 13'h000, 2'd0, 1'b0, 1'b1, 1'b0);
    return c;
  endfunction

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy_o !== 1'b0 && k < 100);
    if (busy_o !== 1'b0) chk("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_drain(input int left);
    int k = 0;
    while (q.size() > left && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > left) begin
      chk("drain_timeout", q.size(), left);
      q.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd"},  {29'd0, cmd_o}, {29'd0, NOP});
    chk({tag, "_addr"}, {19'd0, addr_o}, 32'd0);
    chk({tag, "_bank"}, {30'd0, bank_o}, 32'd0);
    chk({tag, "_acks"}, {29'd0, ack_o, ref_ack_o, lmr_ack_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  typedef struct {
    int          kind;
    logic        w;
    logic [31:0] ad;
    int          path;
  } vec_t;
  vec_t tbl[13];

  task automatic run_vec(input vec_t v);
    int n;
    wait_idle();
    n = cyc;
    case (v.kind)
      K_ACC: begin req = 1'b1; we = v.w; addr = v.ad; void'(push_acc(n, v.path, v.w, v.ad)); end
      K_REF: begin ref_req = 1'b1; void'(push_ref(n, v.path, 1'b0)); end
      default: begin lmr_req = 1'b1; void'(push_ref(n, v.path, 1'b1)); end
    endcase
    wait_drain(0);
    req = 1'b0; ref_req = 1'b0; lmr_req = 1'b0;
  endtask

  initial begin
    int n, a1, r;
    rst = 1'b1; req = 1'b0; we = 1'b0; ref_req = 1'b0; lmr_req = 1'b0; addr = '0;

    tbl[0]  = '{K_ACC, 1'b0, 32'h0100_0804, P_CLOSED};
    tbl[1]  = '{K_ACC, 1'b0, 32'h0100_0808, P_HIT};
    tbl[2]  = '{K_ACC, 1'b1, 32'h0100_1004, P_MISS};
    tbl[3]  = '{K_ACC, 1'b0, 32'h0200_0000, P_CLOSED};
    tbl[4]  = '{K_ACC, 1'b1, 32'h0200_0FFC, P_MISS};
    tbl[5]  = '{K_ACC, 1'b0, 32'h03FF_FFFC, P_CLOSED};
    tbl[6]  = '{K_REF, 1'b0, 32'h0,          P_OPEN};
    tbl[7]  = '{K_ACC, 1'b0, 32'h0100_1004, P_CLOSED};
    tbl[8]  = '{K_LMR, 1'b0, 32'h0,          P_OPEN};
    tbl[9]  = '{K_LMR, 1'b0, 32'h0,          P_CLOSED};
    tbl[10] = '{K_REF, 1'b0, 32'h0,          P_CLOSED};
    tbl[11] = '{K_ACC, 1'b1, 32'h0000_0000, P_CLOSED};
    tbl[12] = '{K_ACC, 1'b1, 32'h0000_0004, P_HIT};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Request held through ack: the cycle after IDLE is a fresh request.
    wait_idle();
    n = cyc; req = 1'b1; we = 1'b0; addr = 32'h0000_0008;
    a1 = push_acc(n, P_HIT, 1'b0, addr);
    void'(push_acc(a1 + 1, P_HIT, 1'b0, addr));
    wait_drain(0);
    req = 1'b0;

    // Refresh and access together with bank 1 open: refresh wins.
    run_vec('{K_ACC, 1'b0, 32'h0100_0804, P_CLOSED});
    wait_idle();
    n = cyc; ref_req = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0100_0804;
    r = push_ref(n, P_OPEN, 1'b0);
    void'(push_acc(r + T_RFC, P_CLOSED, 1'b0, addr));
    wait_drain(2);
    ref_req = 1'b0;
    wait_drain(0);
    req = 1'b0;

    // Reset during ACT_WAIT: sequence abandoned, row forgotten.
    wait_idle();
    n = cyc; req = 1'b1; we = 1'b0; addr = 32'h0200_2800;
    push(n + 1, ACT, 13'h005, 2'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0; req = 1'b0;
    chk("mid_reset_queue", q.size(), 0);
    q.delete();
    run_vec('{K_ACC, 1'b0, 32'h0200_2800, P_CLOSED});

    repeat (12) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkmc_sdram_cmdgen.md
# pkmc_sdram_cmdgen

Parametrised SDRAM command and address sequencer for the PKMC memory controller. Turns a single-word access request (byte address plus read/write) into a timed PRECHARGE/ACTIVE/READ/WRITE sequence. Keeps an open-row table per bank, services refresh and mode-register requests, and drives registered command, address and bank lines to the SDRAM pad logic. The data path and CAS-latency capture sit downstream and key off `ack_o`.

## Interface
- `ADDR_W`, 32: width of the request byte address.
- `SDRAM_ADDR_W`, 13: width of the SDRAM A bus; must be at least 11.
- `BANK_W`, 2: bank select width.
- `ROW_W`, 13: row field width; must not exceed SDRAM_ADDR_W.
- `COL_W`, 9: column field width; must not exceed 10.
- `COL_LSB`, 2: position of the column field in `addr_i`.
- `ROW_LSB`, 11: position of the row field in `addr_i`.
- `BANK_LSB`, 24: position of the bank field in `addr_i`.
- `T_RP`, 2: precharge-to-command cycles; at least 1.
- `T_RCD`, 2: activate-to-read/write cycles; at least 1.
- `T_RFC`, 7: refresh-to-command cycles; at least 1.
- `MODE_WORD`, 13'h022: A-bus value driven with LMR.

Ports:
- `clk_i`, in, 1: clock. Everything is on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `req_i`, in, 1: access request. Held high until `ack_o`.
- `we_i`, in, 1: 1 selects write, 0 selects read. Stable while `req_i` is high.
- `addr_i`, in, ADDR_W: byte address. Stable while `req_i` is high.
- `ref_req_i`, in, 1: refresh request. Held high until `ref_ack_o`.
- `lmr_req_i`, in, 1: load-mode-register request. Held high until `lmr_ack_o`.
- `cmd_o`, out, 3: {ras_n, cas_n, we_n}. Encodings: NOP 111, ACT 011, RD 101, WR 100, PRE 010, REF 001, LMR 000.
- `addr_o`, out, SDRAM_ADDR_W: SDRAM A bus.
- `bank_o`, out, BANK_W: SDRAM BA bus.
- `ack_o`, out, 1: one-cycle pulse in the cycle `cmd_o` carries RD or WR.
- `ref_ack_o`, out, 1: one-cycle pulse with the REF command.
- `lmr_ack_o`, out, 1: one-cycle pulse with the LMR command.
- `busy_o`, out, 1: high whenever the state is not IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - `cmd_o` = 111 (NOP); `addr_o` = 0; `bank_o` = 0.
  - All acks = 0; `busy_o` = 0.
  - State = IDLE; every bank is marked closed.
- Reset mid-sequence abandons the sequence: NOP in the next cycle, no ack issued.
- Request priority is evaluated only in IDLE: `lmr_req_i` first, then `ref_req_i`, then `req_i`. A simultaneous lower-priority request waits.
- Open-row table: one valid bit plus a ROW_W row register per bank.
- Access path, selected by the target bank's table entry:
  - Bank open, row hit: go to RW.
  - Bank open, row miss: PRE (single bank) → PRE_WAIT → ACT → ACT_WAIT → RW.
  - Bank closed: ACT → ACT_WAIT → RW.
- Table updates:
  - ACT sets the bank's valid bit and stores its row.
  - PRE single clears that bank's valid bit; PRE all clears every valid bit.
- Refresh path: PRE all (skipped if no bank is open) → PRE_WAIT → REF → REF_WAIT (T_RFC) → IDLE.
- LMR path: PRE all (skipped if no bank is open) → PRE_WAIT → LMR → IDLE.
- Address rules:
  - PRE single: A10 = 0, `bank_o` = target bank.
  - PRE all: A10 = 1; all other A bits are 0.
  - ACT: `addr_o` = row field, zero-extended to SDRAM_ADDR_W. `bank_o` = bank field `addr_i[BANK_LSB +: BANK_W]`.
  - RD/WR: `addr_o` = column field, zero-extended. A10 = the auto-precharge bit (see Configuration).
  - LMR: `addr_o` = MODE_WORD, `bank_o` = 0.
  - REF: `addr_o` = 0.
- Every command occupies exactly one cycle on `cmd_o`. All other cycles drive NOP.
- A single down-counter, sized for max(T_RP, T_RCD, T_RFC), is loaded when PRE, ACT or REF issues.

## Timing
Take the request as sampled in IDLE at cycle N.
- Row hit: RD/WR and `ack_o` at N+1.
- Bank closed: ACT at N+1; RD/WR at N+1+T_RCD.
- Row miss: PRE at N+1; ACT at N+1+T_RP; RD/WR at N+1+T_RP+T_RCD.
- Refresh, all banks closed: REF and `ref_ack_o` at N+1; back in IDLE at N+1+T_RFC.
- Refresh, some bank open: PRE all at N+1; REF at N+1+T_RP.
- LMR, some bank open: PRE all at N+1; LMR at N+1+T_RP; back in IDLE at N+2+T_RP.
- After any ack the block is in IDLE the following cycle. The next request can therefore reach `cmd_o` no earlier than 2 cycles after the previous ack.
- `req_i` still high in the cycle after `ack_o` is a new request.

## Configuration
- `PKMC_AUTO_PRECHARGE_EN` defined: close-page policy.
  - RD/WR drive A10 = 1, and the bank's valid bit is cleared when RD/WR issues.
  - Every access takes the bank-closed path.
  - After an auto-precharged RD/WR, an ACT to the same bank is held until T_RP cycles have passed.
- `PKMC_AUTO_PRECHARGE_EN` undefined: open-page policy. A10 = 0 on RD/WR, and the row table is used as described above.

## Test plan
Defaults T_RP = 2, T_RCD = 2, T_RFC = 7; open-page policy unless noted.
- Reset, then read 0x0100_0804 (bank 1, row 1, col 1):
  - ACT at N+1 with addr_o = 0x001, bank_o = 1.
  - RD at N+3 with addr_o = 0x001 and `ack_o` high.
- Read 0x0100_0808, same row: RD at N+1 with addr_o = 0x002 and no ACT.
- Write 0x0100_1004 (bank 1, row 2):
  - PRE at N+1 with A10 = 0, bank_o = 1.
  - ACT with row 0x002 at N+3.
  - WR at N+5.
- `ref_req_i` and `req_i` raised together with bank 1 open:
  - PRE with addr_o = 0x400 at N+1, REF with `ref_ack_o` at N+3.
  - Access then begins with ACT (all banks closed).
- `rst_i` asserted during ACT_WAIT: NOP the next cycle, no `ack_o`. A following access to the same row issues ACT again.
- With `PKMC_AUTO_PRECHARGE_EN`, two reads to the same row: each issues ACT, then RD with A10 = 1. The second ACT is no earlier than T_RP cycles after the first RD.
